// File: rtl/neopixel_tx_gen_if.sv
// Host-side bundle for neopixel_tx_gen: FIFO write port, control inputs, status and serial line.
// NEO_OVF_FLAG_EN adds the sticky overflow flag fifo_ovf_o.
interface neopixel_tx_gen_if #(
  parameter int unsigned PIXEL_BITS = 24,
  parameter int unsigned FIFO_AW    = 10
);
  logic                  neo_mode_i;
  logic                  neo_tx_enable_i;
  logic                  neo_msgTyp_i;
  logic [PIXEL_BITS-1:0] neo_rgb_i;
  logic                  wr_en_i;
  logic                  fifo_full_flg_o;
  logic                  fifo_empty_flg_o;
  logic [FIFO_AW:0]      fifo_level_o;
  logic                  neo_busy_o;
  logic                  neopixel_tx_o;
`ifdef NEO_OVF_FLAG_EN
  logic                  fifo_ovf_o;

  modport master (
    output neo_mode_i, neo_tx_enable_i, neo_msgTyp_i, neo_rgb_i, wr_en_i,
    input  fifo_full_flg_o, fifo_empty_flg_o, fifo_level_o, neo_busy_o, neopixel_tx_o,
           fifo_ovf_o
  );
  modport slave (
    input  neo_mode_i, neo_tx_enable_i, neo_msgTyp_i, neo_rgb_i, wr_en_i,
    output fifo_full_flg_o, fifo_empty_flg_o, fifo_level_o, neo_busy_o, neopixel_tx_o,
           fifo_ovf_o
  );
`else
  modport master (
    output neo_mode_i, neo_tx_enable_i, neo_msgTyp_i, neo_rgb_i, wr_en_i,
    input  fifo_full_flg_o, fifo_empty_flg_o, fifo_level_o, neo_busy_o, neopixel_tx_o
  );
  modport slave (
    input  neo_mode_i, neo_tx_enable_i, neo_msgTyp_i, neo_rgb_i, wr_en_i,
    output fifo_full_flg_o, fifo_empty_flg_o, fifo_level_o, neo_busy_o, neopixel_tx_o
  );
`endif
endinterface

// File: rtl/neopixel_tx_gen.sv
// WS2812-style serial transmitter fed by a pixel+latch-flag FIFO, with gapless prefetch.
// Optional: define NEO_OVF_FLAG_EN for the sticky write-while-full flag fifo_ovf_o.
module neopixel_tx_gen #(
  parameter int unsigned CLK_HZ     = 20000000,
  parameter int unsigned PIXEL_BITS = 24,
  parameter int unsigned FIFO_AW    = 10,
  parameter int unsigned LATCH_US   = 50
) (
  input  logic            clk_i,
  input  logic            neo_rst_i,
  neopixel_tx_gen_if.slave bus
);

  localparam longint T0H_F   = (64'(CLK_HZ) * 64'd400)  / 64'd1000000000;
  localparam longint T1H_F   = (64'(CLK_HZ) * 64'd800)  / 64'd1000000000;
  localparam longint PER_F   = (64'(CLK_HZ) * 64'd1250) / 64'd1000000000;
  localparam longint T0H_S   = (64'(CLK_HZ) * 64'd500)  / 64'd1000000000;
  localparam longint T1H_S   = (64'(CLK_HZ) * 64'd1200) / 64'd1000000000;
  localparam longint PER_S   = (64'(CLK_HZ) * 64'd2500) / 64'd1000000000;
  localparam longint LATCH_N = (64'(LATCH_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam longint MAX_CNT = (LATCH_N > PER_S) ? LATCH_N : PER_S;
  localparam int     CNT_W   = $clog2(MAX_CNT + 1);
  localparam int     BC_W    = $clog2(PIXEL_BITS + 1);
  localparam int     DEPTH   = 2 ** FIFO_AW;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [BC_W-1:0]    bcnt_t;
  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0]   lvl_t;

  // Counters hold "cycles remaining minus one" so a phase ends on the zero cycle.
  localparam cnt_t H0F = cnt_t'(T0H_F - 1);
  localparam cnt_t H1F = cnt_t'(T1H_F - 1);
  localparam cnt_t L0F = cnt_t'(PER_F - T0H_F - 1);
  localparam cnt_t L1F = cnt_t'(PER_F - T1H_F - 1);
  localparam cnt_t H0S = cnt_t'(T0H_S - 1);
  localparam cnt_t H1S = cnt_t'(T1H_S - 1);
  localparam cnt_t L0S = cnt_t'(PER_S - T0H_S - 1);
  localparam cnt_t L1S = cnt_t'(PER_S - T1H_S - 1);
  localparam cnt_t LAT = cnt_t'(LATCH_N - 1);

  function automatic cnt_t hi_cnt(input logic fast, input logic b);
    cnt_t c;
    if (fast) c = b ? H1F : H0F;
    else      c = b ? H1S : H0S;
    return c;
  endfunction

  function automatic cnt_t lo_cnt(input logic fast, input logic b);
    cnt_t c;
    if (fast) c = b ? L1F : L0F;
    else      c = b ? L1S : L0S;
    return c;
  endfunction

  // ---------------- FIFO ----------------
  logic [PIXEL_BITS:0] mem [DEPTH];
  logic [PIXEL_BITS:0] rd_q;
  ptr_t                wptr_q, rptr_q;
  lvl_t                level_q, level_d;
  logic                full_q, empty_q;
  logic                wr_ok, pop;

  assign wr_ok   = bus.wr_en_i & ~full_q;
  assign level_d = level_q + lvl_t'(wr_ok) - lvl_t'(pop);

  always_ff @(posedge clk_i) begin
    if (neo_rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + ptr_t'(1);
      if (pop)   rptr_q <= rptr_q + ptr_t'(1);
      level_q <= level_d;
      full_q  <= (level_d == lvl_t'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Pops only happen while non-empty, so a same-cycle write never targets the read slot.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr_q] <= {bus.neo_msgTyp_i, bus.neo_rgb_i};
    if (pop)   rd_q        <= mem[rptr_q];
  end

`ifdef NEO_OVF_FLAG_EN
  logic ovf_q;
  always_ff @(posedge clk_i) begin
    if (neo_rst_i) ovf_q <= 1'b0;
    else if (bus.wr_en_i && full_q) ovf_q <= 1'b1;
  end
  assign bus.fifo_ovf_o = ovf_q;
`endif

  // ---------------- Encoder FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;

  state_t                state_q;
  cnt_t                  cnt_q;
  bcnt_t                 bitcnt_q;
  logic [PIXEL_BITS-1:0] sh_q;
  logic                  flag_q, mode_q, pf_q, first_low_q, tx_q;

  always_comb begin
    pop = 1'b0;
    if (!empty_q && bus.neo_tx_enable_i) begin
      if (state_q == S_IDLE) pop = 1'b1;
      else if (state_q == S_LOW && first_low_q && bitcnt_q == bcnt_t'(1) && !flag_q)
        pop = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (neo_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      sh_q        <= '0;
      flag_q      <= 1'b0;
      mode_q      <= 1'b0;
      pf_q        <= 1'b0;
      first_low_q <= 1'b0;
      tx_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (pop) state_q <= S_FETCH;
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          sh_q     <= rd_q[PIXEL_BITS-1:0];
          flag_q   <= rd_q[PIXEL_BITS];
          bitcnt_q <= bcnt_t'(PIXEL_BITS);
          mode_q   <= bus.neo_mode_i;
          cnt_q    <= hi_cnt(bus.neo_mode_i, rd_q[PIXEL_BITS-1]);
          tx_q     <= 1'b1;
          state_q  <= S_HIGH;
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            tx_q        <= 1'b0;
            cnt_q       <= lo_cnt(mode_q, sh_q[PIXEL_BITS-1]);
            first_low_q <= 1'b1;
            state_q     <= S_LOW;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_LOW: begin
          first_low_q <= 1'b0;
          if (pop) pf_q <= 1'b1;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - cnt_t'(1);
          end else if (bitcnt_q != bcnt_t'(1)) begin
            sh_q     <= sh_q << 1;
            bitcnt_q <= bitcnt_q - bcnt_t'(1);
            cnt_q    <= hi_cnt(mode_q, sh_q[PIXEL_BITS-2]);
            tx_q     <= 1'b1;
            state_q  <= S_HIGH;
          end else if (pf_q) begin
            // Prefetched word is already in rd_q: start its first HIGH with no gap.
            pf_q     <= 1'b0;
            sh_q     <= rd_q[PIXEL_BITS-1:0];
            flag_q   <= rd_q[PIXEL_BITS];
            bitcnt_q <= bcnt_t'(PIXEL_BITS);
            mode_q   <= bus.neo_mode_i;
            cnt_q    <= hi_cnt(bus.neo_mode_i, rd_q[PIXEL_BITS-1]);
            tx_q     <= 1'b1;
            state_q  <= S_HIGH;
          end else if (flag_q) begin
            cnt_q   <= LAT;
            state_q <= S_LATCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LATCH: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - cnt_t'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_full_flg_o  = full_q;
  assign bus.fifo_empty_flg_o = empty_q;
  assign bus.fifo_level_o     = level_q;
  assign bus.neo_busy_o       = (state_q != S_IDLE);
  assign bus.neopixel_tx_o    = tx_q;

endmodule

// File: tb/tb_neopixel_tx_gen.sv
// Directed bench for neopixel_tx_gen at 20 MHz: decodes the serial line into bit timings and words.
module tb_neopixel_tx_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  neopixel_tx_gen_if #(.PIXEL_BITS(24), .FIFO_AW(4)) bus ();

  neopixel_tx_gen #(.CLK_HZ(20000000), .PIXEL_BITS(24), .FIFO_AW(4), .LATCH_US(50)) dut (
    .clk_i    (clk),
    .neo_rst_i(rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int hi_exp(input logic md, input logic b);
    if (md) return b ? 16 : 8;
    return b ? 24 : 10;
  endfunction

  function automatic int lo_exp(input logic md, input logic b);
    if (md) return b ? 9 : 17;
    return b ? 26 : 40;
  endfunction

  function automatic logic [23:0] dat(input int i);
    return 24'((i * 32'h000B1D37) ^ 32'h005AA5C3);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [23:0] d, input logic typ);
    bus.neo_rgb_i    = d;
    bus.neo_msgTyp_i = typ;
    bus.wr_en_i      = 1'b1;
    @(negedge clk);
    bus.wr_en_i      = 1'b0;
  endtask

  // One bit: cycles waited for the rise, then high run, then low run (capped by maxlo).
  task automatic meas(input int maxlo, output int hi, output int lo, output int t);
    t = 0; hi = 0; lo = 0;
    while (bus.neopixel_tx_o !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      t = -1;
      return;
    end
    while (bus.neopixel_tx_o === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    while (bus.neopixel_tx_o === 1'b0 && lo < maxlo) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic rx_word(input int nbits, input logic md, input int last_lo, input int drop_at,
                         output logic [23:0] w, output int bad, output int lat);
    int hi, lo, t;
    logic b;
    w = '0; bad = 0; lat = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) bus.neo_tx_enable_i = 1'b0;
      meas((i == nbits - 1) ? last_lo : 5000, hi, lo, t);
      if (i == 0) lat = t;
      if (t < 0) begin
        bad++;
        return;
      end
      b = (hi == hi_exp(md, 1'b1));
      if (hi != hi_exp(md, b)) bad++;
      if (lo != lo_exp(md, b)) bad++;
      w = {w[22:0], b};
    end
  endtask

  // Counts cycles until busy falls, and any high line samples in that window.
  task automatic busy_run(output int n, output int txhi);
    n = 0; txhi = 0;
    while (bus.neo_busy_o === 1'b1 && n < 5000) begin
      if (bus.neopixel_tx_o !== 1'b0) txhi++;
      n++;
      @(negedge clk);
    end
  endtask

  logic [23:0] w;
  int bad, lat, n, txhi;

  initial begin
    bus.neo_mode_i      = 1'b1;
    bus.neo_tx_enable_i = 1'b0;
    bus.neo_msgTyp_i    = 1'b0;
    bus.neo_rgb_i       = '0;
    bus.wr_en_i         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    bus.neopixel_tx_o, 0);
    chk("rst_busy",  bus.neo_busy_o, 0);
    chk("rst_empty", bus.fifo_empty_flg_o, 1);
    chk("rst_full",  bus.fifo_full_flg_o, 0);
    chk("rst_level", bus.fifo_level_o, 0);
`ifdef NEO_OVF_FLAG_EN
    chk("rst_ovf",   bus.fifo_ovf_o, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1: single flagged word at 800 kHz, then 1000-cycle latch
    bus.neo_mode_i = 1'b1; bus.neo_tx_enable_i = 1'b1;
    wr(24'hFF0000, 1'b1);
    rx_word(24, 1'b1, 17, -1, w, bad, lat);
    chk("t1_lat", lat, 3);
    chk("t1_word", w, 24'hFF0000);
    chk("t1_bad", bad, 0);
    busy_run(n, txhi);
    chk("t1_latch", n, 1000);
    chk("t1_latch_tx", txhi, 0);
    chk("t1_idle", bus.neo_busy_o, 0);

    // 2: 400 kHz, unflagged, straight to IDLE
    do_reset();
    bus.neo_mode_i = 1'b0;
    wr(24'h000001, 1'b0);
    rx_word(24, 1'b0, 26, -1, w, bad, lat);
    chk("t2_lat", lat, 3);
    chk("t2_word", w, 24'h000001);
    chk("t2_bad", bad, 0);
    chk("t2_busy", bus.neo_busy_o, 0);
    busy_run(n, txhi);
    chk("t2_nolatch", n, 0);

    // 3: back-to-back words via prefetch
    do_reset();
    bus.neo_mode_i = 1'b1;
    wr(24'h5A0F0F, 1'b0);
    wr(24'hC3A5F0, 1'b1);
    rx_word(24, 1'b1, 9, -1, w, bad, lat);
    chk("t3_lat1", lat, 2);
    chk("t3_word1", w, 24'h5A0F0F);
    chk("t3_bad1", bad, 0);
    rx_word(24, 1'b1, 17, -1, w, bad, lat);
    chk("t3_gap", lat, 0);
    chk("t3_word2", w, 24'hC3A5F0);
    chk("t3_bad2", bad, 0);
    busy_run(n, txhi);
    chk("t3_latch", n, 1000);

    // 4: fill to full (16 entries here), overflow write, then drain in order
    do_reset();
    bus.neo_tx_enable_i = 1'b0;
    for (int i = 0; i < 15; i++) wr(dat(i), 1'b0);
    chk("t4_full15", bus.fifo_full_flg_o, 0);
    chk("t4_lvl15", bus.fifo_level_o, 15);
    wr(dat(15), 1'b0);
    chk("t4_full", bus.fifo_full_flg_o, 1);
    chk("t4_lvl16", bus.fifo_level_o, 16);
    chk("t4_nempty", bus.fifo_empty_flg_o, 0);
    wr(24'hDEAD00, 1'b1);
    chk("t4_ovf_lvl", bus.fifo_level_o, 16);
    chk("t4_ovf_full", bus.fifo_full_flg_o, 1);
`ifdef NEO_OVF_FLAG_EN
    chk("t4_ovf_flag", bus.fifo_ovf_o, 1);
`endif
    bus.neo_tx_enable_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [23:0] e;
      e = dat(i);
      rx_word(24, 1'b1, lo_exp(1'b1, e[0]), -1, w, bad, lat);
      chk($sformatf("t4_lat%0d", i), lat, (i == 0) ? 3 : 0);
      chk($sformatf("t4_word%0d", i), w, e);
      chk($sformatf("t4_bad%0d", i), bad, 0);
    end
    chk("t4_end_busy", bus.neo_busy_o, 0);
    chk("t4_end_empty", bus.fifo_empty_flg_o, 1);
    chk("t4_end_lvl", bus.fifo_level_o, 0);

    // 5: reset during HIGH of the fifth bit
    do_reset();
    bus.neo_tx_enable_i = 1'b0;
    wr(24'hF0F0F0, 1'b0); wr(24'h111111, 1'b0); wr(24'h222222, 1'b0);
    bus.neo_tx_enable_i = 1'b1;
    rx_word(4, 1'b1, 9, -1, w, bad, lat);
    chk("t5_bits", w[3:0], 4'hF);
    chk("t5_bad", bad, 0);
    chk("t5_in_high", bus.neopixel_tx_o, 1);
    chk("t5_lvl_pre", bus.fifo_level_o, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx", bus.neopixel_tx_o, 0);
    chk("t5_lvl", bus.fifo_level_o, 0);
    chk("t5_empty", bus.fifo_empty_flg_o, 1);
    chk("t5_busy", bus.neo_busy_o, 0);
    rst = 1'b0;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.neopixel_tx_o !== 1'b0 || bus.neo_busy_o !== 1'b0) n++;
    end
    chk("t5_quiet", n, 0);

    // 6: enable dropped mid-word, flagged first word still completes with latch
    do_reset();
    bus.neo_tx_enable_i = 1'b0;
    wr(24'h3C3C3C, 1'b1); wr(24'h123456, 1'b0); wr(24'h654321, 1'b0);
    bus.neo_tx_enable_i = 1'b1;
    rx_word(24, 1'b1, 17, 2, w, bad, lat);
    chk("t6_lat", lat, 3);
    chk("t6_word", w, 24'h3C3C3C);
    chk("t6_bad", bad, 0);
    busy_run(n, txhi);
    chk("t6_latch", n, 1000);
    chk("t6_lvl", bus.fifo_level_o, 2);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.neopixel_tx_o !== 1'b0 || bus.neo_busy_o !== 1'b0) n++;
    end
    chk("t6_held", n, 0);
    bus.neo_tx_enable_i = 1'b1;
    rx_word(24, 1'b1, 17, -1, w, bad, lat);
    chk("t6_lat2", lat, 3);
    chk("t6_word2", w, 24'h123456);
    chk("t6_bad2", bad, 0);
    rx_word(24, 1'b1, 9, -1, w, bad, lat);
    chk("t6_gap3", lat, 0);
    chk("t6_word3", w, 24'h654321);
    chk("t6_bad3", bad, 0);
    chk("t6_end_busy", bus.neo_busy_o, 0);
    chk("t6_end_empty", bus.fifo_empty_flg_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/neopixel_tx_gen.md
Name: neopixel_tx_gen

Overview:
Parametrised successor to the fixed 20 MHz / 24-bit neopixel transmitter. It combines two parts:
- A single internal FIFO holding the pixel word and the message-type bit together.
- A WS2812-style serial encoder whose bit timing is derived from a clock-frequency parameter.

Pixel width, FIFO depth and latch time are generics. The block adds:
- Zero-gap back-to-back pixels via prefetch.
- A per-word latch command.
- A FIFO level output and a busy output.

Parameters:
CLK_HZ, 20000000, input clock frequency in Hz; all timing counts derive from it (floor of CLK_HZ*ns/1e9, 64-bit elaboration math).
PIXEL_BITS, 24, bits per pixel word (24 = GRB, 32 = GRBW); transmitted MSB first.
FIFO_AW, 10, FIFO address width; depth = 2**FIFO_AW entries, all usable.
LATCH_US, 50, line-low latch time in microseconds.

Ports:
clk_i  in  1  system clock
neo_rst_i  in  1  synchronous reset, active-high
neo_mode_i  in  1  speed select: 1 = 800 kHz, 0 = 400 kHz
neo_tx_enable_i  in  1  transmit enable
neo_msgTyp_i  in  1  message type: 1 = send latch after this word, 0 = data only
neo_rgb_i  in  PIXEL_BITS  pixel word written to the FIFO
wr_en_i  in  1  FIFO write strobe, one entry per cycle high
fifo_full_flg_o  out  1  FIFO full
fifo_empty_flg_o  out  1  FIFO empty
fifo_level_o  out  FIFO_AW+1  entries held in the FIFO
neo_busy_o  out  1  high in any state other than IDLE
neopixel_tx_o  out  1  serial line (registered)

Behaviour:
- Reset values: FIFO cleared (level 0, empty = 1, full = 0); FSM in IDLE; neopixel_tx_o = 0; busy = 0. Reset mid-frame drops the line low on the next edge and discards the shift register.
- Timing counts, per mode:
  - 800 kHz: T0H = 400 ns, T1H = 800 ns, bit period = 1250 ns.
  - 400 kHz: T0H = 500 ns, T1H = 1200 ns, bit period = 2500 ns.
  - At 20 MHz: 8 / 16 / 25 and 10 / 24 / 50 cycles.
  - Latch = LATCH_US*CLK_HZ/1e6 cycles (1000 at defaults).
  - Counter widths are sized by $clog2 of the largest count.
- FIFO:
  - Width PIXEL_BITS+1; synchronous read data, valid the cycle after the pop.
  - A write while full is ignored, even if a pop occurs in the same cycle.
  - Simultaneous write and pop while not full leaves the level unchanged.
  - Flags and level are registered and update on the edge after the write or pop.
- FSM states: IDLE, FETCH, LOAD, HIGH, LOW, LATCH.
  - IDLE: if enable and not empty, pop and go to FETCH.
  - FETCH: one cycle waiting for read data.
  - LOAD: capture word and flag into the shift register; set bit counter to PIXEL_BITS; sample neo_mode_i. The mode is held for the whole word; mid-word mode changes are ignored.
  - HIGH: line = 1 for TxH cycles, where TxH is chosen by the current MSB.
  - LOW: line = 0 for period minus TxH cycles, then shift and decrement the bit counter.
- Prefetch: on the first LOW cycle of the last bit, if the word's flag = 0 and enable = 1 and the FIFO is not empty, pop. At the end of that LOW, load the fetched word and enter HIGH directly, giving no gap between words.
- End of word without prefetch:
  - Flag = 1: go to LATCH (line 0 for the latch count), then IDLE.
  - Flag = 0: go to IDLE. The line stays low; reaching the latch time is the host's responsibility.
- Enable deassertion: deasserting mid-word completes the current word and its latch (if flagged), suppresses prefetch, then the FSM returns to IDLE.
- Empty mid-stream: an empty FIFO at the prefetch point means no pop; the FSM enters IDLE after the word.

Optional Feature:
Macro NEO_OVF_FLAG_EN.
- Defined: adds output port fifo_ovf_o (1 bit), a sticky flag set on the edge after any write attempted while full. It is cleared only by neo_rst_i; reset value 0.
- Undefined: the port and logic are absent, and ignored writes are silent.

Test Plan:
1. Defaults, mode = 1: write 0xFF0000 with msgTyp = 1, enable = 1 -> line starts high 3 cycles after the write (pop, FETCH, LOAD). It then shows 8 bits of 16-high/9-low, then 16 bits of 8-high/17-low, then 1000 low cycles; busy falls after LATCH.
2. Mode = 0: single word 0x000001, msgTyp = 0 -> 23 bits of 10/40, last bit 24/26, then IDLE with no LATCH state.
3. Two words, msgTyp 0 then 1 -> the second word's first HIGH begins the cycle after the first word's last LOW ends; total 48 bit periods of 25 cycles, then latch.
4. Write 1024 words with enable = 0 -> full = 1, level = 1024. A 1025th write is ignored, and fifo_ovf_o = 1 when NEO_OVF_FLAG_EN is defined. Enabling then drains all words in order.
5. Assert neo_rst_i during HIGH of bit 5 -> line 0 next edge; level 0; empty = 1; busy = 0. Enable held high with no writes gives no output.
6. Drop enable mid-word with 3 words queued, first flagged -> first word plus latch complete; level stays 2; the FSM idles until enable returns.
